// File: rtl/sonar_measurement_sequencer_if.sv
// Signal bundle between the game FSM / sensor pins (master) and the sonar sequencer (slave).
interface sonar_measurement_sequencer_if;
    // start is a one-cycle request taken only when the sequencer is idle or done; busy covers the
    // whole sequence, done pulses once on success, and abort overrides any request in flight.
    logic       start;
    logic       abort;
    logic [8:0] target_cm;
    logic [3:0] tolerance_cm;
    logic       echo;
    logic       trigger;
    logic       busy;
    logic [8:0] distance_cm;
    logic       measure_valid;
    logic       timeout;
    logic [2:0] hit_count;
    logic       done;
    logic [3:0] db_state;

    modport master (
        output start, abort, target_cm, tolerance_cm, echo,
        input  trigger, busy, distance_cm, measure_valid, timeout, hit_count, done, db_state
    );

    modport slave (
        input  start, abort, target_cm, tolerance_cm, echo,
        output trigger, busy, distance_cm, measure_valid, timeout, hit_count, done, db_state
    );
endinterface

// File: rtl/sonar_measurement_sequencer.sv
// Ultrasonic trigger/echo sequencer: measures distance with round-half-up conversion and
// reports success after REQUIRED_HITS consecutive in-window readings.
module sonar_measurement_sequencer #(
    parameter int unsigned CLK_HZ           = 50_000_000,
    parameter int unsigned TRIGGER_CYCLES   = 500,
    parameter int unsigned CYCLES_PER_CM    = 2941,
    parameter int unsigned ECHO_WAIT_CYCLES = 1_500_000,
    parameter int unsigned MAX_ECHO_CYCLES  = 1_500_000,
    parameter int unsigned INTERVAL_CYCLES  = 3_000_000,
    parameter int unsigned REQUIRED_HITS    = 5
) (
    input logic                          clock,
    input logic                          reset,
    sonar_measurement_sequencer_if.slave bus
);
    // One shared counter spanning a full second of clocks covers every wait period.
    localparam int unsigned CNT_W = $clog2(CLK_HZ + 1);
    localparam int unsigned SUB_W = $clog2(CYCLES_PER_CM + 1);
    localparam logic [SUB_W-1:0] HALF_CM  = SUB_W'(CYCLES_PER_CM / 2);
    localparam logic [SUB_W-1:0] LAST_SUB = SUB_W'(CYCLES_PER_CM - 1);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_TRIG      = 4'd1,
        ST_WAIT_ECHO = 4'd2,
        ST_MEASURE   = 4'd3,
        ST_EVAL      = 4'd4,
        ST_GAP       = 4'd5,
        ST_DONE      = 4'd6
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic [8:0]       cm_q, cm_d;
    logic [8:0]       target_q, target_d;
    logic [3:0]       tol_q, tol_d;
    logic [2:0]       hit_q, hit_d;
    logic [8:0]       dist_q, dist_d;
    logic             mv_q, mv_d;
    logic             to_q, to_d;
    logic             done_q, done_d;
    logic             echo_meta_q, echo_meta_d;
    logic             echo_sync_q, echo_sync_d;
    logic             echo_prev_q, echo_prev_d;

    logic             echo_rise;
    logic [SUB_W-1:0] sub_base, sub_inc;
    logic [8:0]       cm_base, cm_inc;
    logic signed [9:0] diff;
    logic [9:0]       diff_abs;
    logic             in_window;
    logic [2:0]       hit_inc;

    always_comb begin
        echo_meta_d = bus.echo;
        echo_sync_d = echo_meta_q;
        echo_prev_d = echo_sync_q;
        // Edge-based detection: entering WAIT_ECHO with echo high needs a fall before a new rise.
        echo_rise   = echo_sync_q & ~echo_prev_q;

        // The rising-edge clock is the first counted high clock, seeded from half a centimetre.
        sub_base = (state_q == ST_WAIT_ECHO) ? HALF_CM : sub_q;
        cm_base  = (state_q == ST_WAIT_ECHO) ? 9'd0 : cm_q;
        if (sub_base == LAST_SUB) begin
            sub_inc = '0;
            cm_inc  = (cm_base == 9'd511) ? cm_base : cm_base + 9'd1;
        end else begin
            sub_inc = sub_base + SUB_W'(1);
            cm_inc  = cm_base;
        end

        diff      = $signed({1'b0, cm_q}) - $signed({1'b0, target_q});
        diff_abs  = diff[9] ? $unsigned(-diff) : $unsigned(diff);
        in_window = (diff_abs <= {6'd0, tol_q});
        hit_inc   = hit_q + 3'd1;

        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        sub_d    = sub_q;
        cm_d     = cm_q;
        target_d = target_q;
        tol_d    = tol_q;
        hit_d    = hit_q;
        dist_d   = dist_q;
        mv_d     = 1'b0;
        to_d     = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    target_d = bus.target_cm;
                    tol_d    = bus.tolerance_cm;
                    hit_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_TRIG;
                end
            end
            ST_TRIG: begin
                if (cnt_q == CNT_W'(TRIGGER_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_ECHO;
                end
            end
            ST_WAIT_ECHO: begin
                if (echo_rise) begin
                    sub_d   = sub_inc;
                    cm_d    = cm_inc;
                    cnt_d   = CNT_W'(1);
                    state_d = ST_MEASURE;
                end else if (cnt_q == CNT_W'(ECHO_WAIT_CYCLES - 1)) begin
                    to_d    = 1'b1;
                    hit_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end
            end
            ST_MEASURE: begin
                if (!echo_sync_q) begin
                    state_d = ST_EVAL;
                end else if (cnt_q == CNT_W'(MAX_ECHO_CYCLES)) begin
                    to_d    = 1'b1;
                    hit_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    sub_d = sub_inc;
                    cm_d  = cm_inc;
                end
            end
            ST_EVAL: begin
                dist_d = cm_q;
                mv_d   = 1'b1;
                cnt_d  = '0;
                if (in_window) begin
                    hit_d = hit_inc;
                    if (hit_inc == 3'(REQUIRED_HITS)) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_GAP;
                    end
                end else begin
                    hit_d   = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(INTERVAL_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_TRIG;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort beats any start in the same cycle and leaves the latched window untouched.
        if (bus.abort) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            hit_d    = '0;
            target_d = target_q;
            tol_d    = tol_q;
            mv_d     = 1'b0;
            to_d     = 1'b0;
            done_d   = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sub_q       <= '0;
            cm_q        <= '0;
            target_q    <= '0;
            tol_q       <= '0;
            hit_q       <= '0;
            dist_q      <= '0;
            mv_q        <= 1'b0;
            to_q        <= 1'b0;
            done_q      <= 1'b0;
            echo_meta_q <= 1'b0;
            echo_sync_q <= 1'b0;
            echo_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sub_q       <= sub_d;
            cm_q        <= cm_d;
            target_q    <= target_d;
            tol_q       <= tol_d;
            hit_q       <= hit_d;
            dist_q      <= dist_d;
            mv_q        <= mv_d;
            to_q        <= to_d;
            done_q      <= done_d;
            echo_meta_q <= echo_meta_d;
            echo_sync_q <= echo_sync_d;
            echo_prev_q <= echo_prev_d;
        end
    end

    assign bus.trigger       = (state_q == ST_TRIG);
    assign bus.busy          = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign bus.distance_cm   = dist_q;
    assign bus.measure_valid = mv_q;
    assign bus.timeout       = to_q;
    assign bus.hit_count     = hit_q;
    assign bus.done          = done_q;
    assign bus.db_state      = state_q;
endmodule

// File: doc/sonar_measurement_sequencer.md
Name: sonar_measurement_sequencer

Overview:
- Sequences the ultrasonic range sensor (trigger/echo) for the sensor stage of the neurosync game.
- On `start`, runs repeated measurement cycles: trigger pulse, echo capture, timeout, distance conversion with rounding.
- Compares each result against a target window and declares success after REQUIRED_HITS consecutive in-window readings.
- Sits between the game FSM (start/abort/done) and the sensor pins; also feeds distance to the 7-seg/serial path.

Parameters:
- CLK_HZ, 50_000_000, clock frequency (documentation only).
- TRIGGER_CYCLES, 500, trigger pulse width in clocks (10 us).
- CYCLES_PER_CM, 2941, echo clocks per cm (58.82 us).
- ECHO_WAIT_CYCLES, 1_500_000, maximum clocks from trigger fall to echo rise before timeout (30 ms).
- MAX_ECHO_CYCLES, 1_500_000, maximum echo-high clocks before timeout.
- INTERVAL_CYCLES, 3_000_000, idle gap between measurement cycles (60 ms).
- REQUIRED_HITS, 5, consecutive in-window readings needed (1..7).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a sequence when idle.
- abort  in  1  level or pulse; returns to IDLE.
- target_cm  in  9  window centre, sampled on accepted start.
- tolerance_cm  in  4  window half-width, sampled on accepted start.
- echo  in  1  asynchronous sensor echo.
- trigger  out  1  sensor trigger.
- busy  out  1  high in every state except IDLE and DONE.
- distance_cm  out  9  last converted distance, held.
- measure_valid  out  1  one-cycle pulse when distance_cm updates.
- timeout  out  1  one-cycle pulse on a timed-out measurement.
- hit_count  out  3  current consecutive-hit count.
- done  out  1  one-cycle pulse when REQUIRED_HITS is reached.
- db_state  out  4  state encoding for debug display.

Behaviour:
- Reset (reset=0 at a clock edge):
  - All outputs 0 and state IDLE.
  - Internal counters 0 and echo synchronizer cleared.
- Echo path:
  - `echo` passes through a 2-FF synchronizer; all echo decisions use the synchronized value.
  - This adds 2 clocks of fixed latency, applied symmetrically to rise and fall.
- States (db_state): IDLE=0, TRIG=1, WAIT_ECHO=2, MEASURE=3, EVAL=4, GAP=5, DONE=6.
- IDLE:
  - `start` latches target_cm and tolerance_cm, clears hit_count, goes to TRIG.
- TRIG:
  - trigger=1 for exactly TRIGGER_CYCLES clocks, then WAIT_ECHO.
- WAIT_ECHO:
  - Entry with echo already high: wait for it to fall before accepting a rising edge.
  - Synchronized echo rising edge: go to MEASURE and set the width counter so the first high clock counts 1.
  - ECHO_WAIT_CYCLES elapsed with no rising edge: pulse timeout, clear hit_count, go to GAP.
- MEASURE:
  - Sub-counter starts at CYCLES_PER_CM/2 (1470) and increments each echo-high clock.
  - When the sub-counter reaches CYCLES_PER_CM it wraps to 0 and the cm counter increments.
  - Result: distance = floor((cycles + CYCLES_PER_CM/2) / CYCLES_PER_CM), i.e. round-half-up.
  - cm counter saturates at 511.
  - On echo fall: go to EVAL.
  - Echo high for more than MAX_ECHO_CYCLES: pulse timeout, clear hit_count, go to GAP; distance_cm unchanged.
- EVAL (one clock):
  - distance_cm <= cm counter; pulse measure_valid.
  - In window when |distance − target| ≤ tolerance. Compute in 10-bit signed; the window is clamped at 0 and 511.
  - Hit: hit_count+1. If the new value equals REQUIRED_HITS, go to DONE; otherwise go to GAP.
  - Miss: hit_count <= 0, go to GAP.
- GAP:
  - Wait INTERVAL_CYCLES, then TRIG. Trigger stays low throughout.
- DONE:
  - done=1 for the entry clock only; state stays DONE.
  - hit_count and distance_cm hold.
  - `start` begins a new sequence exactly as from IDLE.
- abort:
  - Highest priority after reset. In any state, the next edge goes to IDLE, trigger=0, busy=0.
  - hit_count cleared; distance_cm held.
  - abort and start in the same cycle: abort wins.
- start while busy: ignored; latched target/tolerance unchanged.
- Timing:
  - trigger rises the clock after start is accepted.
  - done rises the clock after the final EVAL.
- Echo edges arriving in TRIG, GAP, IDLE or DONE are ignored.

Test Plan (bench overrides INTERVAL_CYCLES=20000, ECHO_WAIT_CYCLES=MAX_ECHO_CYCLES=400000; others default):
- Reset 0 for 3 clocks, then start with target=75, tol=2 -> trigger high exactly 500 clocks; busy=1, db_state 1→2.
- No echo after first trigger -> timeout pulse after 400000 clocks in WAIT_ECHO; hit_count=0; next trigger after 20000-clock gap.
- Echo 5882 us -> distance_cm=100, measure_valid pulse, hit_count stays 0. Echo 5899 us -> 100. Echo 4353 us -> 74.
- Five consecutive 4399 us echoes -> distance_cm=75 each time; hit_count 1..5; done one-cycle pulse after the fifth EVAL; db_state=6; no further trigger.
- Three hits, one 5882 us miss, then five hits -> hit_count resets to 0 at the miss; done only after the fifth post-miss hit.
- abort asserted mid-MEASURE (echo still high) -> IDLE the next clock, trigger=0, busy=0, hit_count=0, no measure_valid; start same cycle as abort -> stays IDLE.
